// File: rtl/uart_pkg.sv
// Shared ASCII constants, parser state type and width helper
// for the UART hex word parser.
package uart_pkg;

  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CM = 8'h2C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_LFH = 8'h66;
  localparam logic [7:0] CH_UA = 8'h41;
  localparam logic [7:0] CH_UF = 8'h46;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_OUTPUT,
    ST_DISCARD
  } parse_state_e;

  function automatic int data_width(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/hex_char_decode.sv
// Combinational ASCII classifier: hex digit value or
// word terminator (space, comma, CR, LF).
module hex_char_decode
  import uart_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic       is_term_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_digit_o = 1'b1;
    nibble_o   = '0;
    unique case (1'b1)
      (char_i >= CH_0 && char_i <= CH_9):
        nibble_o = 4'(char_i - CH_0);
      (char_i >= CH_LA && char_i <= CH_LFH):
        nibble_o = 4'(char_i - CH_LA + 8'd10);
      (char_i >= CH_UA && char_i <= CH_UF):
        nibble_o = 4'(char_i - CH_UA + 8'd10);
      default:
        is_digit_o = 1'b0;
    endcase
  end

  assign is_term_o = (char_i == CH_SP) || (char_i == CH_CM) ||
                     (char_i == CH_CR) || (char_i == CH_LF);

endmodule

// File: rtl/uart_hex_word_parser.sv
// Turns an ASCII hex byte stream into right-justified words
// on a valid/ready port, holding upstream off while a word waits.
module uart_hex_word_parser
  import uart_pkg::*;
#(
  parameter  int WORD_DIGITS = 8,
  localparam int DATA_WIDTH  = data_width(WORD_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [7:0]            s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  error_o
);

  localparam int CW = $clog2(WORD_DIGITS + 1);

  parse_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  is_digit;
  logic                  is_term;
  logic [3:0]            nibble;
  logic                  accept;
  logic [DATA_WIDTH-1:0] shifted;

  hex_char_decode u_dec (
    .char_i     (s_data_i),
    .is_digit_o (is_digit),
    .is_term_o  (is_term),
    .nibble_o   (nibble)
  );

  assign s_ready_o = (state_q != ST_OUTPUT);
  assign m_valid_o = (state_q == ST_OUTPUT);
  assign m_data_o  = data_q;
  assign error_o   = err_q;
  assign accept    = s_valid_i && s_ready_o;
  assign shifted   = {acc_q[DATA_WIDTH-5:0], nibble};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q == CW'(WORD_DIGITS - 1)) begin
              data_d  = shifted;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = ST_OUTPUT;
            end else begin
              acc_d   = shifted;
              cnt_d   = cnt_q + CW'(1);
              state_d = ST_COLLECT;
            end
          end else if (is_term) begin
            // a terminator with no digits pending is just whitespace
            if (state_q == ST_COLLECT) begin
              data_d  = acc_q;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = ST_OUTPUT;
            end
          end else begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_OUTPUT: begin
        if (m_ready_i) state_d = ST_IDLE;
      end
      ST_DISCARD: begin
        if (accept && is_term) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_hex_word_parser.sv
// Scoreboard bench: stimulus queues expected words/errors,
// a negedge monitor pops and compares them as the DUT emits.
module tb_uart_hex_word_parser;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [7:0]  s_data_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic        error_o;

  uart_hex_word_parser dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    int          c;
  } exp_t;

  exp_t        wq[$];
  int          eq[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          ncmp = 0;
  int          nerr = 0;
  logic        prev_v = 1'b0;
  logic [31:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    s_valid_i = 1'b1;
    s_data_i  = b;
    @(negedge clk);
    while (!s_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready_o) chk("send_timeout", 64'(s_ready_o), 64'd1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    s_valid_i = 1'b0;
  endtask

  task automatic exp_word(input logic [31:0] w);
    exp_t e;
    e.w = w;
    e.c = acc_cyc;
    wq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_i) begin
      prev_v = 1'b0;
    end else begin
      if (m_valid_o) begin
        if (!prev_v) begin
          if (wq.size() == 0) begin
            chk("unexpected_word", 64'(m_data_o), 64'hFFFF_FFFF_FFFF);
          end else begin
            exp_t e;
            e = wq.pop_front();
            held = e.w;
            chk("word_data", 64'(m_data_o), 64'(e.w));
            chk("word_latency", 64'(cyc), 64'(e.c));
          end
        end else begin
          chk("hold_data", 64'(m_data_o), 64'(held));
        end
      end
      prev_v = m_valid_o;
      if (error_o) begin
        if (eq.size() == 0) begin
          chk("unexpected_error", 64'(error_o), 64'd0);
        end else begin
          chk("error_latency", 64'(cyc), 64'(eq.pop_front()));
        end
      end
    end
  end

  initial begin
    reset_i   = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    m_ready_i = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_valid", 64'(m_valid_o), 64'd0);
    chk("rst_data", 64'(m_data_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    chk("rst_ready", 64'(s_ready_o), 64'd1);
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // "1A2b\n"
    send("1"); send("A"); send("2"); send("b");
    send(8'h0A); exp_word(32'h0000_1A2B);
    idle(3);

    // full word, then a trailing LF that must be ignored
    send("D"); send("E"); send("A"); send("D");
    send("B"); send("E"); send("E");
    send("F"); exp_word(32'hDEAD_BEEF);
    send(8'h0A);
    idle(3);

    // backpressure hold
    m_ready_i = 1'b0;
    send("7"); send(8'h0A); exp_word(32'h0000_0007);
    s_valid_i = 1'b1;
    s_data_i  = "9";
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 64'(m_valid_o), 64'd1);
      chk("hold_sready", 64'(s_ready_o), 64'd0);
      @(posedge clk);
      #1;
    end
    m_ready_i = 1'b1;
    @(negedge clk);
    chk("rel_sready_pre", 64'(s_ready_o), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rel_sready", 64'(s_ready_o), 64'd1);
    chk("rel_valid", 64'(m_valid_o), 64'd0);
    @(posedge clk);
    #1;
    send(8'h0A); exp_word(32'h0000_0009);
    idle(3);

    // illegal char, discard, recover
    send("1"); send("2");
    send("G"); eq.push_back(acc_cyc);
    send("4"); send(" ");
    send("5"); send("5");
    send(8'h0A); exp_word(32'h0000_0055);
    idle(3);

    // reset mid-word drops the partial
    send("A"); send("B");
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    send("C"); send(8'h0A); exp_word(32'h0000_000C);
    idle(3);

    // terminators only
    send(" "); send(" "); send(",");
    send(8'h0D); send(8'h0A);
    @(negedge clk);
    chk("term_sready", 64'(s_ready_o), 64'd1);
    chk("term_valid", 64'(m_valid_o), 64'd0);
    idle(4);

    chk("words_left", 64'(wq.size()), 64'd0);
    chk("errors_left", 64'(eq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
